// File: rtl/quantize_seq_ctrl_if.sv
// quantize_seq_ctrl_if: upstream FP32 stream, downstream quantized stream,
// block scale and busy for the quantization sequencer.
interface quantize_seq_ctrl_if #(
   parameter int unsigned FP_DATA_W = 32,
   parameter int unsigned BIT_NUM   = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [FP_DATA_W-1:0] in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [BIT_NUM-1:0]   out_data;
   logic                 out_last;
   logic                 scale_valid;
   logic [FP_DATA_W-1:0] scale_data;
   logic                 busy;

   // Producer/consumer side (testbench or surrounding pipeline)
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last, scale_valid, scale_data, busy
   );

   // Sequencer side
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last, scale_valid, scale_data, busy
   );
endinterface

// File: rtl/quantize_seq_ctrl.sv
// quantize_seq_ctrl: buffers a VEC_LEN block of FP32 values, tracks its absmax,
// publishes it as the block scale, then streams symmetric BIT_NUM-bit codes
// round(x*QMAX/absmax) saturated to +/-QMAX.
// Optional macro QUANT_SEQ_OUT_REG_EN adds a registered output stage after
// the quantizer; without it the output stream is combinational from the buffer.
module quantize_seq_ctrl #(
   parameter int unsigned FP_DATA_W   = 32,
   parameter int unsigned FP_MANT_W   = 23,
   parameter int unsigned FP_EXP_W    = 8,
   parameter int unsigned FP_EXP_BIAS = 127,
   parameter int unsigned BIT_NUM     = 8,
   parameter int unsigned VEC_LEN     = 16
) (
   input  logic               clk,
   input  logic               rst,
   quantize_seq_ctrl_if.slave bus
);

   localparam int unsigned PTR_W       = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   localparam int unsigned MAG_W       = FP_DATA_W - 1;
   localparam int unsigned MANT_FULL_W = FP_MANT_W + 1;
   localparam int unsigned NUM_W       = MANT_FULL_W + BIT_NUM;
   localparam int unsigned EXPD_W      = FP_EXP_W + 2;
   localparam int unsigned QMAX        = (1 << (BIT_NUM - 1)) - 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(VEC_LEN - 1);

   typedef enum logic [0:0] {
      S_LOAD  = 1'b0,
      S_QUANT = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [FP_DATA_W-1:0]  r_buf [VEC_LEN];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [MAG_W-1:0]      r_absmax;
   logic [FP_DATA_W-1:0]  r_scale_data;
   logic                  r_scale_valid;

   logic                  w_in_fire;
   logic                  w_wr_last;
   logic [MAG_W-1:0]      w_in_mag;
   logic [MAG_W-1:0]      w_absmax_nxt;
   logic                  w_out_valid;
   logic [BIT_NUM-1:0]    w_out_data;
   logic                  w_out_last;
   logic                  w_out_fire;

   // quantizer signals
   logic [FP_DATA_W-1:0]  w_x;
   logic                  w_x_sign;
   logic [FP_EXP_W-1:0]   w_x_exp;
   logic [FP_EXP_W-1:0]   w_s_exp;
   logic [FP_EXP_W-1:0]   w_x_eeff;
   logic [FP_EXP_W-1:0]   w_s_eeff;
   logic [MANT_FULL_W-1:0] w_x_mfull;
   logic [MANT_FULL_W-1:0] w_s_mfull;
   logic signed [EXPD_W-1:0] w_x_unb;
   logic signed [EXPD_W-1:0] w_s_unb;
   logic signed [EXPD_W-1:0] w_exp_diff;
   logic [NUM_W-1:0]      w_num;
   logic [NUM_W-1:0]      w_den;
   logic [NUM_W-1:0]      w_quo;
   logic [NUM_W-1:0]      w_z;
   logic [NUM_W-1:0]      w_rnd;
   logic                  w_sat;
   logic [BIT_NUM-1:0]    w_mag;
   logic [BIT_NUM-1:0]    w_q;
   logic                  w_scale_zero;

   assign w_in_fire    = bus.in_valid && (r_state == S_LOAD);
   assign w_wr_last    = (r_wr_ptr == LAST_PTR);
   assign w_in_mag     = bus.in_data[FP_DATA_W-2:0];
   assign w_absmax_nxt = ((r_wr_ptr == '0) || (w_in_mag > r_absmax)) ? w_in_mag : r_absmax;
   assign w_out_fire   = w_out_valid && bus.out_ready;

   // Operand decode: denormals use exponent 1 without hidden bit
   assign w_x          = r_buf[r_rd_ptr];
   assign w_x_sign     = w_x[FP_DATA_W-1];
   assign w_x_exp      = w_x[FP_DATA_W-2 -: FP_EXP_W];
   assign w_s_exp      = r_scale_data[FP_DATA_W-2 -: FP_EXP_W];
   assign w_x_mfull    = {(w_x_exp != '0), w_x[FP_MANT_W-1:0]};
   assign w_s_mfull    = {(w_s_exp != '0), r_scale_data[FP_MANT_W-1:0]};
   assign w_x_eeff     = (w_x_exp == '0) ? FP_EXP_W'(1) : w_x_exp;
   assign w_s_eeff     = (w_s_exp == '0) ? FP_EXP_W'(1) : w_s_exp;
   assign w_x_unb      = $signed({2'b00, w_x_eeff}) - $signed(EXPD_W'(FP_EXP_BIAS));
   assign w_s_unb      = $signed({2'b00, w_s_eeff}) - $signed(EXPD_W'(FP_EXP_BIAS));
   assign w_exp_diff   = w_s_unb - w_x_unb;
   assign w_scale_zero = (r_scale_data[FP_DATA_W-2:0] == '0);

   // Quotient carries one extra fraction bit so rounding is (z+1)>>1
   assign w_num = NUM_W'(2 * QMAX) * NUM_W'(w_x_mfull);
   assign w_den = (w_s_mfull == '0) ? NUM_W'(1) : NUM_W'(w_s_mfull);
   assign w_quo = w_num / w_den;

   // Align by exponent difference, round half away from zero, saturate to QMAX
   always_comb begin
      w_z   = '0;
      w_sat = 1'b0;
      if (w_exp_diff[EXPD_W-1]) begin
         w_sat = 1'b1;
      end else if (w_exp_diff < $signed(EXPD_W'(NUM_W))) begin
         w_z = w_quo >> w_exp_diff;
      end
      w_rnd = (w_z + NUM_W'(1)) >> 1;
      w_mag = (w_sat || (w_rnd > NUM_W'(QMAX))) ? BIT_NUM'(QMAX) : w_rnd[BIT_NUM-1:0];
      if (w_scale_zero) begin
         w_q = '0;
      end else if (w_x_sign) begin
         w_q = ~w_mag + BIT_NUM'(1);
      end else begin
         w_q = w_mag;
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_LOAD;
      else     r_state <= w_state_nxt;
   end

   // Next-state: load a full block, then drain it
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_LOAD:  if (w_in_fire && w_wr_last)   w_state_nxt = S_QUANT;
         S_QUANT: if (w_out_fire && w_out_last) w_state_nxt = S_LOAD;
         default: w_state_nxt = S_LOAD;
      endcase
   end

   // Input side: buffer write, absmax tracking, scale publish
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < VEC_LEN; i++) r_buf[i] <= '0;
         r_wr_ptr      <= '0;
         r_absmax      <= '0;
         r_scale_data  <= '0;
         r_scale_valid <= 1'b0;
      end else begin
         r_scale_valid <= 1'b0;
         if (w_in_fire) begin
            r_buf[r_wr_ptr] <= bus.in_data;
            r_absmax        <= w_absmax_nxt;
            if (w_wr_last) begin
               r_wr_ptr      <= '0;
               r_scale_data  <= {1'b0, w_absmax_nxt};
               r_scale_valid <= 1'b1;
            end else begin
               r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
         end
      end
   end

`ifdef QUANT_SEQ_OUT_REG_EN
   logic               r_out_valid;
   logic [BIT_NUM-1:0] r_out_data;
   logic               r_out_last;
   logic               r_drain;
   logic               w_stage_free;
   logic               w_issue;

   assign w_stage_free = !r_out_valid || bus.out_ready;
   assign w_issue      = (r_state == S_QUANT) && !r_drain && w_stage_free;

   // Read pointer and output stage; reloads whenever empty or accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_ptr    <= '0;
         r_drain     <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
      end else begin
         if (w_issue) begin
            r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
            if (r_rd_ptr == LAST_PTR) r_drain <= 1'b1;
         end else if (w_out_fire && r_out_last) begin
            r_drain <= 1'b0;
         end
         if (w_stage_free) begin
            r_out_valid <= w_issue;
            r_out_data  <= w_issue ? w_q : '0;
            r_out_last  <= w_issue && (r_rd_ptr == LAST_PTR);
         end
      end
   end

   assign w_out_valid = r_out_valid;
   assign w_out_data  = r_out_data;
   assign w_out_last  = r_out_last;
`else
   assign w_out_valid = (r_state == S_QUANT);
   assign w_out_data  = w_out_valid ? w_q : '0;
   assign w_out_last  = w_out_valid && (r_rd_ptr == LAST_PTR);

   // Read pointer advances on each downstream acceptance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_ptr <= '0;
      end else if (w_out_fire) begin
         r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
      end
   end
`endif

   assign bus.in_ready    = (r_state == S_LOAD);
   assign bus.busy        = (r_state == S_QUANT);
   assign bus.out_valid   = w_out_valid;
   assign bus.out_data    = w_out_data;
   assign bus.out_last    = w_out_last;
   assign bus.scale_valid = r_scale_valid;
   assign bus.scale_data  = r_scale_data;

endmodule

// File: tb/tb_quantize_seq_ctrl.sv
// Directed self-checking bench for quantize_seq_ctrl (either output build).
`timescale 1ns/1ps
module tb_quantize_seq_ctrl;

   localparam int unsigned VEC_LEN = 16;
`ifdef QUANT_SEQ_OUT_REG_EN
   localparam int PERIOD = 33;
`else
   localparam int PERIOD = 32;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   quantize_seq_ctrl_if #(.FP_DATA_W(32), .BIT_NUM(8)) bus ();

   quantize_seq_ctrl #(
      .FP_DATA_W(32), .FP_MANT_W(23), .FP_EXP_W(8), .FP_EXP_BIAS(127),
      .BIT_NUM(8), .VEC_LEN(VEC_LEN)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] blk    [VEC_LEN];
   logic [7:0]  exp_q  [VEC_LEN];
   logic [31:0] exp_scale;
   logic [7:0]  got      [VEC_LEN];
   logic        got_last [VEC_LEN];
   int n_got, n_scale_pulse, n_inrdy, n_unstable;

   // Block A: 2.0 at index 3 is the absmax
   task automatic set_block_a();
      for (int i = 0; i < VEC_LEN; i++) begin blk[i] = 32'h3E80_0000; exp_q[i] = 8'h10; end
      blk[0] = 32'h3F80_0000; exp_q[0] = 8'h40;
      blk[1] = 32'hC000_0000; exp_q[1] = 8'h81;
      blk[2] = 32'h3F00_0000; exp_q[2] = 8'h20;
      blk[3] = 32'h4000_0000; exp_q[3] = 8'h7F;
      blk[4] = 32'h0000_0000; exp_q[4] = 8'h00;
      exp_scale = 32'h4000_0000;
   endtask

   // Block B: -3.0 absmax; 1.5 -> 64, 1.0 -> 42, 0.75 -> 32
   task automatic set_block_b();
      for (int i = 0; i < VEC_LEN; i++) begin
         blk[i]   = (i % 2 == 0) ? 32'h3FC0_0000 : 32'h3F80_0000;
         exp_q[i] = (i % 2 == 0) ? 8'h40 : 8'h2A;
      end
      blk[5]  = 32'hC040_0000; exp_q[5]  = 8'h81;
      blk[15] = 32'h3F40_0000; exp_q[15] = 8'h20;
      exp_scale = 32'h4040_0000;
   endtask

   task automatic load_block();
      for (int i = 0; i < VEC_LEN; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = blk[i];
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
   endtask

   // Drain one block, recording transfers and side observations
   task automatic collect_block(input bit toggle);
      int          ncyc;
      bit          prev_stall;
      logic [7:0]  prev_data;
      logic        prev_last;
      n_got = 0; n_scale_pulse = 0; n_inrdy = 0; n_unstable = 0;
      ncyc = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
      while (n_got < VEC_LEN && ncyc < 200) begin
         bus.out_ready = toggle ? (ncyc % 2 == 0) : 1'b1;
         #0;
         if (bus.scale_valid) n_scale_pulse++;
         if (bus.in_ready)    n_inrdy++;
         if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== prev_data
                            || bus.out_last !== prev_last)) n_unstable++;
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;
         prev_last  = bus.out_last;
         if (bus.out_valid && bus.out_ready) begin
            got[n_got]      = bus.out_data;
            got_last[n_got] = bus.out_last;
            n_got++;
         end
         @(posedge clk); #1;
         ncyc++;
      end
      bus.out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
      #2;
      checks++; if (bus.in_ready !== 1'b1)     begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0)    begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
      checks++; if (bus.out_data !== 8'h00)    begin errors++; $display("FAIL reset_out_data got %h exp 00", bus.out_data); end
      checks++; if (bus.out_last !== 1'b0)     begin errors++; $display("FAIL reset_out_last got %b exp 0", bus.out_last); end
      checks++; if (bus.scale_valid !== 1'b0)  begin errors++; $display("FAIL reset_scale_valid got %b exp 0", bus.scale_valid); end
      checks++; if (bus.scale_data !== 32'h0)  begin errors++; $display("FAIL reset_scale_data got %h exp 0", bus.scale_data); end
      checks++; if (bus.busy !== 1'b0)         begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic_block();
      set_block_a();
      load_block();
      checks++; if (bus.scale_valid !== 1'b1)    begin errors++; $display("FAIL basic_scale_pulse got %b exp 1", bus.scale_valid); end
      checks++; if (bus.scale_data !== exp_scale) begin errors++; $display("FAIL basic_scale_data got %h exp %h", bus.scale_data, exp_scale); end
      checks++; if (bus.busy !== 1'b1)           begin errors++; $display("FAIL basic_busy got %b exp 1", bus.busy); end
      checks++; if (bus.in_ready !== 1'b0)       begin errors++; $display("FAIL basic_in_ready got %b exp 0", bus.in_ready); end
      collect_block(1'b0);
      checks++; if (n_got !== VEC_LEN) begin errors++; $display("FAIL basic_count got %0d exp %0d", n_got, VEC_LEN); end
      for (int i = 0; i < n_got; i++) begin
         checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL basic_data[%0d] got %h exp %h", i, got[i], exp_q[i]); end
         checks++; if (got_last[i] !== (i == VEC_LEN - 1)) begin errors++; $display("FAIL basic_last[%0d] got %b exp %b", i, got_last[i], (i == VEC_LEN - 1)); end
      end
      checks++; if (n_scale_pulse !== 1)        begin errors++; $display("FAIL basic_scale_pulses got %0d exp 1", n_scale_pulse); end
      checks++; if (bus.busy !== 1'b0)          begin errors++; $display("FAIL basic_busy_after got %b exp 0", bus.busy); end
      checks++; if (bus.scale_data !== exp_scale) begin errors++; $display("FAIL basic_scale_hold got %h exp %h", bus.scale_data, exp_scale); end
   endtask

   task automatic test_zero_block();
      for (int i = 0; i < VEC_LEN; i++) begin blk[i] = 32'h0; exp_q[i] = 8'h00; end
      blk[7] = 32'h8000_0000;
      load_block();
      checks++; if (bus.scale_data !== 32'h0) begin errors++; $display("FAIL zero_scale_data got %h exp 0", bus.scale_data); end
      collect_block(1'b0);
      checks++; if (n_got !== VEC_LEN) begin errors++; $display("FAIL zero_count got %0d exp %0d", n_got, VEC_LEN); end
      for (int i = 0; i < n_got; i++) begin
         checks++; if (got[i] !== 8'h00) begin errors++; $display("FAIL zero_data[%0d] got %h exp 00", i, got[i]); end
      end
   endtask

   task automatic test_negative_absmax();
      set_block_b();
      load_block();
      checks++; if (bus.scale_data !== exp_scale) begin errors++; $display("FAIL neg_scale_data got %h exp %h", bus.scale_data, exp_scale); end
      collect_block(1'b0);
      checks++; if (n_got !== VEC_LEN) begin errors++; $display("FAIL neg_count got %0d exp %0d", n_got, VEC_LEN); end
      for (int i = 0; i < n_got; i++) begin
         checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL neg_data[%0d] got %h exp %h", i, got[i], exp_q[i]); end
      end
   endtask

   task automatic test_backpressure();
      set_block_a();
      load_block();
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h7F00_0000;
      collect_block(1'b1);
      bus.in_valid = 1'b0;
      checks++; if (n_got !== VEC_LEN) begin errors++; $display("FAIL bp_count got %0d exp %0d", n_got, VEC_LEN); end
      for (int i = 0; i < n_got; i++) begin
         checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL bp_data[%0d] got %h exp %h", i, got[i], exp_q[i]); end
         checks++; if (got_last[i] !== (i == VEC_LEN - 1)) begin errors++; $display("FAIL bp_last[%0d] got %b exp %b", i, got_last[i], (i == VEC_LEN - 1)); end
      end
      checks++; if (n_unstable !== 0) begin errors++; $display("FAIL bp_stable got %0d unstable cycles exp 0", n_unstable); end
      checks++; if (n_inrdy !== 0)    begin errors++; $display("FAIL bp_in_ready got %0d ready cycles exp 0", n_inrdy); end
      checks++; if (bus.scale_data !== exp_scale) begin errors++; $display("FAIL bp_scale_hold got %h exp %h", bus.scale_data, exp_scale); end
   endtask

   task automatic test_reset_midblock();
      for (int i = 0; i < 7; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 32'h4100_0000;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      #1;
      checks++; if (bus.scale_data !== 32'h0) begin errors++; $display("FAIL rstmid_scale_data got %h exp 0", bus.scale_data); end
      checks++; if (bus.out_valid !== 1'b0)   begin errors++; $display("FAIL rstmid_out_valid got %b exp 0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1)    begin errors++; $display("FAIL rstmid_in_ready got %b exp 1", bus.in_ready); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < VEC_LEN; i++) begin blk[i] = 32'h3F00_0000; exp_q[i] = 8'h40; end
      blk[0] = 32'h3F80_0000; exp_q[0] = 8'h7F;
      blk[9] = 32'hBE00_0000; exp_q[9] = 8'hF0;
      exp_scale = 32'h3F80_0000;
      load_block();
      checks++; if (bus.scale_data !== exp_scale) begin errors++; $display("FAIL rstmid_new_scale got %h exp %h", bus.scale_data, exp_scale); end
      collect_block(1'b0);
      checks++; if (n_got !== VEC_LEN) begin errors++; $display("FAIL rstmid_count got %0d exp %0d", n_got, VEC_LEN); end
      for (int i = 0; i < n_got; i++) begin
         checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_data[%0d] got %h exp %h", i, got[i], exp_q[i]); end
      end
      checks++; if (n_scale_pulse !== 1) begin errors++; $display("FAIL rstmid_scale_pulses got %0d exp 1", n_scale_pulse); end
   endtask

   task automatic test_back_to_back();
      int t0, t1, t2;
      set_block_a();
      t0 = cyc_cnt;
      load_block();
      collect_block(1'b0);
      t1 = cyc_cnt;
      checks++; if (t1 - t0 !== PERIOD) begin errors++; $display("FAIL b2b_period0 got %0d exp %0d", t1 - t0, PERIOD); end
      for (int i = 0; i < n_got; i++) begin
         checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_a_data[%0d] got %h exp %h", i, got[i], exp_q[i]); end
      end
      set_block_b();
      load_block();
      checks++; if (bus.scale_data !== exp_scale) begin errors++; $display("FAIL b2b_b_scale got %h exp %h", bus.scale_data, exp_scale); end
      collect_block(1'b0);
      t2 = cyc_cnt;
      checks++; if (t2 - t1 !== PERIOD) begin errors++; $display("FAIL b2b_period1 got %0d exp %0d", t2 - t1, PERIOD); end
      checks++; if (n_got !== VEC_LEN) begin errors++; $display("FAIL b2b_count got %0d exp %0d", n_got, VEC_LEN); end
      for (int i = 0; i < n_got; i++) begin
         checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_b_data[%0d] got %h exp %h", i, got[i], exp_q[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic_block();
      test_zero_block();
      test_negative_absmax();
      test_backpressure();
      test_reset_midblock();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1);
   end

endmodule
